// File: rtl/phase1_datapath.sv
// Phase-1 Mini-SRC datapath: one shared 32-bit bus, GPRs R1/R3/R5, PC, IR, MAR, MDR,
// Y, a 64-bit Z and a combinational ALU (A=Y, B=bus), stepped by an external sequencer.
module phase1_datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Clear_n,
  input  logic             R1in,
  input  logic             R3in,
  input  logic             R5in,
  input  logic             MARin,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             Zin,
  input  logic             MDRin,
  input  logic             IncrementPC,
  input  logic             PCout,
  input  logic             ZLOout,
  input  logic             MDRout,
  input  logic             R3out,
  input  logic             R5out,
  input  logic             Read,
  input  logic [4:0]       ALUControl,
  input  logic [WIDTH-1:0] Mdatain,
  output logic [WIDTH-1:0] big_boy_bus,
  output logic [WIDTH-1:0] R1_data_out,
  output logic [WIDTH-1:0] R3_data_out,
  output logic [WIDTH-1:0] R5_data_out,
  output logic [WIDTH-1:0] MDR_data_in,
  output logic [WIDTH-1:0] MDR_data_out,
  output logic [WIDTH-1:0] Y_data_out,
  output logic [WIDTH-1:0] Z_data_out,
  output logic [WIDTH-1:0] ZLO_data_out,
  output logic [WIDTH-1:0] PC_data_out,
  output logic [WIDTH-1:0] IR_data_out,
  output logic [WIDTH-1:0] MAR_data_out
);

  localparam logic [4:0] OP_PASS = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [WIDTH-1:0]   r1, r3, r5, pc, ir, mar, mdr, y;
  logic [2*WIDTH-1:0] z;
  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_res;

  // Priority resolves illegal multi-driver control words deterministically.
  always_comb begin
    bus = '0;
    if (PCout)       bus = pc;
    else if (ZLOout) bus = z[WIDTH-1:0];
    else if (MDRout) bus = mdr;
    else if (R3out)  bus = r3;
    else if (R5out)  bus = r5;
  end

  assign MDR_data_in = Read ? Mdatain : bus;

  logic [4:0]           sh;
  logic [WIDTH-1:0]     shra_r;
  logic [2*WIDTH-1:0]   yy, ror_full, rol_full;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]   quot, rem;

  assign sh       = bus[4:0];
  assign shra_r   = $signed(y) >>> sh;
  assign yy       = {y, y};
  assign ror_full = yy >> sh;
  assign rol_full = yy << sh;
  assign prod     = $signed({{WIDTH{y[WIDTH-1]}}, y}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});

  always_comb begin
    quot = '0;
    rem  = '0;
    if (bus != '0) begin
      quot = $signed(y) / $signed(bus);
      rem  = $signed(y) % $signed(bus);
    end
  end

  always_comb begin
    alu_res = '0;
    case (ALUControl)
      OP_PASS: alu_res = {{WIDTH{1'b0}}, bus};
      OP_ADD:  alu_res = {{WIDTH{1'b0}}, y + bus};
      OP_SUB:  alu_res = {{WIDTH{1'b0}}, y - bus};
      OP_AND:  alu_res = {{WIDTH{1'b0}}, y & bus};
      OP_OR:   alu_res = {{WIDTH{1'b0}}, y | bus};
      OP_SHR:  alu_res = {{WIDTH{1'b0}}, y >> sh};
      OP_SHRA: alu_res = {{WIDTH{1'b0}}, shra_r};
      OP_SHL:  alu_res = {{WIDTH{1'b0}}, y << sh};
      OP_ROR:  alu_res = {{WIDTH{1'b0}}, ror_full[WIDTH-1:0]};
      OP_ROL:  alu_res = {{WIDTH{1'b0}}, rol_full[2*WIDTH-1:WIDTH]};
      OP_MUL:  alu_res = prod;
      OP_DIV:  alu_res = {rem, quot};
      OP_NEG:  alu_res = {{WIDTH{1'b0}}, -bus};
      OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~bus};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      r1  <= '0;
      r3  <= '0;
      r5  <= '0;
      pc  <= '0;
      ir  <= '0;
      mar <= '0;
      mdr <= '0;
      y   <= '0;
      z   <= '0;
    end else begin
      if (R1in)  r1  <= bus;
      if (R3in)  r3  <= bus;
      if (R5in)  r5  <= bus;
      if (IRin)  ir  <= bus;
      if (MARin) mar <= bus;
      if (Yin)   y   <= bus;
      if (MDRin) mdr <= MDR_data_in;
      if (Zin)   z   <= alu_res;
      if (IncrementPC) pc <= pc + 1'b1;
      else if (PCin)   pc <= bus;
    end
  end

  assign big_boy_bus  = bus;
  assign R1_data_out  = r1;
  assign R3_data_out  = r3;
  assign R5_data_out  = r5;
  assign MDR_data_out = mdr;
  assign Y_data_out   = y;
  assign Z_data_out   = z[2*WIDTH-1:WIDTH];
  assign ZLO_data_out = z[WIDTH-1:0];
  assign PC_data_out  = pc;
  assign IR_data_out  = ir;
  assign MAR_data_out = mar;

endmodule

// File: tb/tb_phase1_datapath.sv
// Directed bench for phase1_datapath: ALU vector table plus reset, load, SHRA,
// fetch, bus-priority and PC sequences with hand-computed expectations.
module tb_phase1_datapath;

  logic        Clock, Clear_n;
  logic        R1in, R3in, R5in, MARin, PCin, IRin, Yin, Zin, MDRin, IncrementPC;
  logic        PCout, ZLOout, MDRout, R3out, R5out, Read;
  logic [4:0]  ALUControl;
  logic [31:0] Mdatain;
  logic [31:0] big_boy_bus, R1_data_out, R3_data_out, R5_data_out, MDR_data_in;
  logic [31:0] MDR_data_out, Y_data_out, Z_data_out, ZLO_data_out;
  logic [31:0] PC_data_out, IR_data_out, MAR_data_out;

  phase1_datapath #(.WIDTH(32)) dut (
    .Clock(Clock), .Clear_n(Clear_n),
    .R1in(R1in), .R3in(R3in), .R5in(R5in), .MARin(MARin), .PCin(PCin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .MDRin(MDRin), .IncrementPC(IncrementPC),
    .PCout(PCout), .ZLOout(ZLOout), .MDRout(MDRout), .R3out(R3out), .R5out(R5out),
    .Read(Read), .ALUControl(ALUControl), .Mdatain(Mdatain),
    .big_boy_bus(big_boy_bus), .R1_data_out(R1_data_out), .R3_data_out(R3_data_out),
    .R5_data_out(R5_data_out), .MDR_data_in(MDR_data_in), .MDR_data_out(MDR_data_out),
    .Y_data_out(Y_data_out), .Z_data_out(Z_data_out), .ZLO_data_out(ZLO_data_out),
    .PC_data_out(PC_data_out), .IR_data_out(IR_data_out), .MAR_data_out(MAR_data_out)
  );

  // clock
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_ctrl();
    {R1in, R3in, R5in, MARin, PCin, IRin, Yin, Zin, MDRin, IncrementPC} = '0;
    {PCout, ZLOout, MDRout, R3out, R5out, Read} = '0;
    ALUControl = 5'b0;
    Mdatain    = 32'h0;
  endtask

  // Apply the current control word across one rising edge, then drop it.
  task automatic cycle();
    @(posedge Clock);
    #1;
    clear_ctrl();
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Read = 1'b1; MDRin = 1'b1; Mdatain = v;
    cycle();
  endtask

  task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    load_mdr(a);
    MDRout = 1'b1; Yin = 1'b1;
    cycle();
    load_mdr(b);
    MDRout = 1'b1; ALUControl = op; Zin = 1'b1;
    cycle();
  endtask

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[22];

  initial begin
    vecs[0]  = '{"pass",     5'b00000, 32'h5,        32'hDEADBEEF, 64'h00000000_DEADBEEF};
    vecs[1]  = '{"add",      5'b00011, 32'h12,       32'h2,        64'h00000000_00000014};
    vecs[2]  = '{"add_wrap", 5'b00011, 32'hFFFFFFFF, 32'h2,        64'h00000000_00000001};
    vecs[3]  = '{"sub_neg",  5'b00100, 32'h5,        32'h7,        64'h00000000_FFFFFFFE};
    vecs[4]  = '{"and",      5'b00101, 32'h12,       32'h2,        64'h00000000_00000002};
    vecs[5]  = '{"or",       5'b00110, 32'hF0F0,     32'h0F0F,     64'h00000000_0000FFFF};
    vecs[6]  = '{"shr",      5'b00111, 32'h80000000, 32'h4,        64'h00000000_08000000};
    vecs[7]  = '{"shr_0",    5'b00111, 32'h80000000, 32'h0,        64'h00000000_80000000};
    vecs[8]  = '{"shra",     5'b01000, 32'h80000000, 32'h4,        64'h00000000_F8000000};
    vecs[9]  = '{"shl",      5'b01001, 32'h1,        32'h1F,       64'h00000000_80000000};
    vecs[10] = '{"ror",      5'b01010, 32'h12345678, 32'h8,        64'h00000000_78123456};
    vecs[11] = '{"ror_0",    5'b01010, 32'h12345678, 32'h20,       64'h00000000_12345678};
    vecs[12] = '{"rol",      5'b01011, 32'h12345678, 32'h8,        64'h00000000_34567812};
    vecs[13] = '{"mul_neg",  5'b01111, 32'hFFFFFFFD, 32'h7,        64'hFFFFFFFF_FFFFFFEB};
    vecs[14] = '{"mul_big",  5'b01111, 32'h00010000, 32'h00010000, 64'h00000001_00000000};
    vecs[15] = '{"div",      5'b10000, 32'd17,       32'd5,        64'h00000002_00000003};
    vecs[16] = '{"div_neg",  5'b10000, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[17] = '{"div_zero", 5'b10000, 32'd17,       32'd0,        64'h00000000_00000000};
    vecs[18] = '{"neg",      5'b10001, 32'h0,        32'h5,        64'h00000000_FFFFFFFB};
    vecs[19] = '{"not",      5'b10010, 32'h0,        32'h0,        64'h00000000_FFFFFFFF};
    vecs[20] = '{"bad_op1",  5'b00001, 32'h7,        32'h7,        64'h00000000_00000000};
    vecs[21] = '{"bad_op31", 5'b11111, 32'h7,        32'h7,        64'h00000000_00000000};
  end

  initial begin
    clear_ctrl();
    Clear_n = 1'b0;
    @(posedge Clock);
    #1;
    check("reset_pc",  {32'h0, PC_data_out},  64'h0);
    check("reset_bus", {32'h0, big_boy_bus},  64'h0);
    check("reset_z",   {Z_data_out, ZLO_data_out}, 64'h0);
    Clear_n = 1'b1;

    // Fetch T0-T2 from PC=0
    PCout = 1'b1; MARin = 1'b1; Zin = 1'b1;
    cycle();
    IncrementPC = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; Mdatain = 32'h28918000;
    cycle();
    MDRout = 1'b1; IRin = 1'b1;
    cycle();
    check("fetch_pc",  {32'h0, PC_data_out},  64'h1);
    check("fetch_ir",  {32'h0, IR_data_out},  64'h28918000);
    check("fetch_mar", {32'h0, MAR_data_out}, 64'h0);

    // Load R3 through MDR
    load_mdr(32'hFFFFFFFE);
    MDRout = 1'b1; R3in = 1'b1;
    cycle();
    check("load_r3", {32'h0, R3_data_out}, 64'hFFFFFFFE);

    // SHRA R1 = R3 >>> R5
    load_mdr(32'h2);
    MDRout = 1'b1; R5in = 1'b1;
    cycle();
    R3out = 1'b1; Yin = 1'b1;
    cycle();
    R5out = 1'b1; ALUControl = 5'b01000; Zin = 1'b1;
    cycle();
    ZLOout = 1'b1; R1in = 1'b1;
    cycle();
    check("shra_r1",  {32'h0, R1_data_out}, 64'hFFFFFFFF);
    check("shra_zhi", {32'h0, Z_data_out},  64'h0);
    check("shra_y",   {32'h0, Y_data_out},  64'hFFFFFFFE);

    // Bus priority and MDR input mux (PC=1, Z=FFFFFFFF, MDR=2, R3=FFFFFFFE, R5=2)
    load_mdr(32'hA5A5A5A5);
    PCout = 1'b1; R5out = 1'b1; #1;
    check("prio_pc", {32'h0, big_boy_bus}, 64'h1);
    clear_ctrl(); ZLOout = 1'b1; MDRout = 1'b1; #1;
    check("prio_zlo", {32'h0, big_boy_bus}, 64'hFFFFFFFF);
    clear_ctrl(); MDRout = 1'b1; R3out = 1'b1; #1;
    check("prio_mdr", {32'h0, big_boy_bus}, 64'hA5A5A5A5);
    clear_ctrl(); R3out = 1'b1; R5out = 1'b1; #1;
    check("prio_r3", {32'h0, big_boy_bus}, 64'hFFFFFFFE);
    clear_ctrl(); R5out = 1'b1; Mdatain = 32'h1234; #1;
    check("mdr_in_bus", {32'h0, MDR_data_in}, 64'h2);
    Read = 1'b1; #1;
    check("mdr_in_mem", {32'h0, MDR_data_in}, 64'h1234);
    clear_ctrl(); #1;
    check("bus_idle", {32'h0, big_boy_bus}, 64'h0);

    // PC load from bus, then increment wraps
    load_mdr(32'hFFFFFFFF);
    MDRout = 1'b1; PCin = 1'b1;
    cycle();
    check("pc_load", {32'h0, PC_data_out}, 64'hFFFFFFFF);
    IncrementPC = 1'b1;
    cycle();
    check("pc_wrap", {32'h0, PC_data_out}, 64'h0);
    // Hold: no enables, registers keep value
    cycle();
    check("r3_hold", {32'h0, R3_data_out}, 64'hFFFFFFFE);

    // ALU table
    for (int i = 0; i < 22; i++) begin
      run_alu(vecs[i].op, vecs[i].a, vecs[i].b);
      check(vecs[i].name, {Z_data_out, ZLO_data_out}, vecs[i].exp);
    end

    // Asynchronous clear mid-cycle
    @(negedge Clock);
    #2;
    Clear_n = 1'b0;
    #1;
    check("aclr_r1",  {32'h0, R1_data_out},  64'h0);
    check("aclr_r3",  {32'h0, R3_data_out},  64'h0);
    check("aclr_r5",  {32'h0, R5_data_out},  64'h0);
    check("aclr_mdr", {32'h0, MDR_data_out}, 64'h0);
    check("aclr_y",   {32'h0, Y_data_out},   64'h0);
    check("aclr_z",   {Z_data_out, ZLO_data_out}, 64'h0);
    check("aclr_ir",  {32'h0, IR_data_out},  64'h0);
    check("aclr_mar", {32'h0, MAR_data_out}, 64'h0);
    ZLOout = 1'b1; #1;
    check("aclr_bus", {32'h0, big_boy_bus}, 64'h0);
    clear_ctrl();
    Clear_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
